sseg_scan_n: RTL and testbench
==============================

Name: sseg_scan_n

Overview:
- Parametrised multiplexed seven-segment driver with N digits and a BIN_W-bit unsigned input.
- Binary-to-BCD conversion runs sequentially (shift-add-3) under a load/busy handshake; results are committed atomically so the display never tears.
- Adds overflow detection, per-digit blink and per-digit decimal-point mask.
- Sits between datapath counters and the board display pins.

Parameters:
N_DIGITS, 4, number of display digits (2..8).
BIN_W, 14, width of the binary input (4..27).
DIV_W, 13, scan advances once every 2^DIV_W clk cycles.
BLINK_W, 24, blink phase is bit BLINK_W-1 of a free-running clk counter.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
bin  in  BIN_W  unsigned value to display.
sign  in  1  negative flag, captured with bin.
load  in  1  capture request; honoured only when busy=0.
valid  in  1  0 forces all digits to dash (live, not captured).
blank_lz  in  1  1 enables leading-zero blanking (live).
dp_mask  in  N_DIGITS  bit i lights the dp on digit i (live).
blink_en  in  N_DIGITS  bit i makes digit i blink (live).
busy  out  1  conversion in progress.
ovf  out  1  last committed value did not fit.
ssegs  out  8  active-low segments {a,b,c,d,e,f,g,dp}.
disp_en  out  N_DIGITS  active-low digit enables, one-hot-low.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - busy=0, ovf=0, ssegs=8'hFF, disp_en all ones.
  - Committed digits=0, committed sign=0.
  - Scan index=0; prescaler and blink counter cleared.
  - Any conversion in progress is aborted with no commit.
- Handshake and latency:
  - load=1 with busy=0 at edge E0 captures bin and sign; busy=1 from E0.
  - The conversion performs one shift-add-3 step per cycle over BIN_W cycles.
  - At edge E0+BIN_W: busy→0 and the digits, sign and ovf are committed together.
  - load while busy=1 is ignored and not queued.
  - A load on the same edge busy falls is also ignored; the next load is accepted one cycle later.
- Overflow:
  - Capacity is 10^N_DIGITS-1 when sign=0, and 10^(N_DIGITS-1)-1 when sign=1.
  - Above capacity: ovf=1 and every digit shows a dash.
  - ovf holds until the next commit.
- Digit content (digit 0 = least significant, rightmost):
  - Codes: 0=03,1=9F,2=25,3=0D,4=99,5=49,6=41,7=1F,8=01,9=09, dash=FD, blank=FF.
  - blank_lz=1: digits above the most-significant non-zero digit show blank; digit 0 is never blanked (value 0 shows "0").
  - sign=1: digit N_DIGITS-1 shows a dash. Blanking still applies to digits 1..N_DIGITS-2.
  - dp: bit0 is driven low when dp_mask[i]=1 for the digit being driven. Multiple dps are allowed.
- Priority per digit, highest first:
  1. valid=0 → FD, no dp.
  2. Blink off-phase and blink_en[i] → FF including dp.
  3. ovf → FD, dp per mask.
  4. Normal content.
- Scan:
  - The prescaler produces a one-cycle tick every 2^DIV_W clks.
  - The index increments on each tick and wraps from N_DIGITS-1 to 0; wrap is explicit, so non-power-of-2 N is supported.
  - disp_en[i]=0 only for i=index; exactly one bit is low at all times after the first post-reset cycle.
  - ssegs and disp_en are registered. They reflect the current index and live inputs with 1-cycle latency and always change on the same edge (no ghosting).
- Blink: off-phase is blink_counter[BLINK_W-1]=1. It is free-running and unaffected by load.
- Display during conversion: the previously committed value is shown for the whole conversion.
- Simultaneous events:
  - rst has priority over load and tick.
  - A tick coinciding with a commit shows the new value on the newly selected digit the following cycle.

Test Plan:
1. N=4, BIN_W=14, DIV_W=2. rst, then load bin=1234 sign=0 → busy high exactly 14 cycles. Across a scan cycle, disp_en=1110/1101/1011/0111 with ssegs 99/0D/25/9F; ovf=0.
2. bin=7, blank_lz=1, then blank_lz=0 → ssegs FF,FF,FF,1F vs 03,03,03,1F on digits 3..0. Then bin=0, blank_lz=1 → digit 0 = 03.
3. bin=999 sign=1 → ovf=0, digit3=FD, digits 2..0=09. Then bin=1000 sign=1 → ovf=1, all digits FD.
4. load bin=42, then load bin=17 on cycle 3 of busy → ignored. Commit shows 42 and the display holds the old value until commit. Then rst on cycle 5 of a new conversion → busy=0, digits 0, ssegs=FF.
5. N=3, DIV_W=1. Index sequence 0,1,2,0 → disp_en 110,101,011,110. dp_mask=101 → bit0 low on digits 0 and 2 only. valid=0 → FD on all digits, dp off.
6. BLINK_W=3, blink_en=0001, bin=5 → digit 0 alternates 49/FF every 4 clks while the other digits are unaffected.

Source files
------------

// File: rtl/sseg_scan_n.sv
// Multiplexed N-digit seven-segment driver with a sequential shift-add-3 binary-to-BCD
// converter, overflow dashes, per-digit blink and decimal-point mask.
module sseg_scan_n #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int DIV_W    = 13,
    parameter int BLINK_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    bin,
    input  logic                sign,
    input  logic                load,
    input  logic                valid,
    input  logic                blank_lz,
    input  logic [N_DIGITS-1:0] dp_mask,
    input  logic [N_DIGITS-1:0] blink_en,
    output logic                busy,
    output logic                ovf,
    output logic [7:0]          ssegs,
    output logic [N_DIGITS-1:0] disp_en
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam int IDX_W = $clog2(N_DIGITS);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam logic [31:0] CAP_POS = 32'(pow10(N_DIGITS) - 1);
    localparam logic [31:0] CAP_NEG = 32'(pow10(N_DIGITS - 1) - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT = N_DIGITS'(1);

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'h03;
            4'd1:    seg_code = 8'h9F;
            4'd2:    seg_code = 8'h25;
            4'd3:    seg_code = 8'h0D;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h49;
            4'd6:    seg_code = 8'h41;
            4'd7:    seg_code = 8'h1F;
            4'd8:    seg_code = 8'h01;
            4'd9:    seg_code = 8'h09;
            default: seg_code = 8'hFD;
        endcase
    endfunction

    logic [BIN_W-1:0] shift_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_next;
    logic [CNT_W-1:0] step_reg;
    logic             busy_reg;
    logic             sign_cap_reg;
    logic             ovf_cap_reg;
    logic [BCD_W-1:0] digits_reg;
    logic             sign_reg;
    logic             ovf_reg;
    logic [31:0]      bin_ext;

    assign bin_ext = 32'(bin);

    // Digits that would leave the display are simply dropped; those cases are
    // already flagged as overflow from the captured binary value.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign bcd_next = {bcd_adj[BCD_W-2:0], shift_reg[BIN_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg     <= 1'b0;
            step_reg     <= '0;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            sign_cap_reg <= 1'b0;
            ovf_cap_reg  <= 1'b0;
            digits_reg   <= '0;
            sign_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
        end else if (!busy_reg) begin
            if (load) begin
                busy_reg     <= 1'b1;
                step_reg     <= '0;
                shift_reg    <= bin;
                bcd_reg      <= '0;
                sign_cap_reg <= sign;
                ovf_cap_reg  <= sign ? (bin_ext > CAP_NEG) : (bin_ext > CAP_POS);
            end
        end else begin
            shift_reg <= shift_reg << 1;
            bcd_reg   <= bcd_next;
            // The last step is committed on the same edge that drops busy.
            if (step_reg == CNT_W'(BIN_W - 1)) begin
                busy_reg   <= 1'b0;
                digits_reg <= bcd_next;
                sign_reg   <= sign_cap_reg;
                ovf_reg    <= ovf_cap_reg;
            end else begin
                step_reg <= step_reg + 1'b1;
            end
        end
    end

    logic [DIV_W-1:0]   presc_reg;
    logic [BLINK_W-1:0] blink_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               tick;

    assign tick = &presc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            blink_reg <= '0;
            idx_reg   <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
            blink_reg <= blink_reg + 1'b1;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    logic [IDX_W-1:0]    msd_next;
    logic [3:0]          cur_digit;
    logic [7:0]          body_next;
    logic [7:0]          ssegs_next;
    logic [N_DIGITS-1:0] en_next;
    logic [7:0]          ssegs_reg;
    logic [N_DIGITS-1:0] disp_en_reg;

    assign cur_digit = digits_reg[4*idx_reg +: 4];

    always_comb begin
        msd_next = '0;
        for (int k = 1; k < N_DIGITS; k++) begin
            if (digits_reg[4*k +: 4] != 4'd0) msd_next = IDX_W'(k);
        end
    end

    always_comb begin
        body_next  = 8'hFF;
        ssegs_next = 8'hFF;
        en_next    = ~(ONE_HOT << idx_reg);
        if (ovf_reg) begin
            body_next = 8'hFD;
        end else if (sign_reg && idx_reg == IDX_W'(N_DIGITS - 1)) begin
            body_next = 8'hFD;
        end else if (blank_lz && idx_reg > msd_next) begin
            body_next = 8'hFF;
        end else begin
            body_next = seg_code(cur_digit);
        end
        if (!valid) begin
            ssegs_next = 8'hFD;
        end else if (blink_reg[BLINK_W-1] && blink_en[idx_reg]) begin
            ssegs_next = 8'hFF;
        end else begin
            ssegs_next = body_next & ~{7'b0, dp_mask[idx_reg]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ssegs_reg   <= 8'hFF;
            disp_en_reg <= '1;
        end else begin
            ssegs_reg   <= ssegs_next;
            disp_en_reg <= en_next;
        end
    end

    assign busy    = busy_reg;
    assign ovf     = ovf_reg;
    assign ssegs   = ssegs_reg;
    assign disp_en = disp_en_reg;

endmodule

// File: tb/tb_sseg_scan_n.sv
// Directed bench for sseg_scan_n: three instances cover a 4-digit fast scan, a 3-digit
// scan and a slow-scan / fast-blink build; expectations are queued and popped on compare.
module tb_sseg_scan_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [13:0] bin_a, bin_b, bin_c;
    logic        sign_a, sign_b, sign_c, load_a, load_b, load_c;
    logic        valid_a, valid_b, valid_c, blank_a, blank_b, blank_c;
    logic [3:0]  dp_a, blink_a, dp_c, blink_c, en_a, en_c;
    logic [2:0]  dp_b, blink_b, en_b;
    logic        busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
    logic [7:0]  seg_a, seg_b, seg_c;

    sseg_scan_n #(.N_DIGITS(4), .BIN_W(14), .DIV_W(2), .BLINK_W(24)) dut_a (
        .clk(clk), .rst(rst), .bin(bin_a), .sign(sign_a), .load(load_a), .valid(valid_a),
        .blank_lz(blank_a), .dp_mask(dp_a), .blink_en(blink_a), .busy(busy_a), .ovf(ovf_a),
        .ssegs(seg_a), .disp_en(en_a));

    sseg_scan_n #(.N_DIGITS(3), .BIN_W(14), .DIV_W(1), .BLINK_W(24)) dut_b (
        .clk(clk), .rst(rst), .bin(bin_b), .sign(sign_b), .load(load_b), .valid(valid_b),
        .blank_lz(blank_b), .dp_mask(dp_b), .blink_en(blink_b), .busy(busy_b), .ovf(ovf_b),
        .ssegs(seg_b), .disp_en(en_b));

    sseg_scan_n #(.N_DIGITS(4), .BIN_W(14), .DIV_W(13), .BLINK_W(3)) dut_c (
        .clk(clk), .rst(rst), .bin(bin_c), .sign(sign_c), .load(load_c), .valid(valid_c),
        .blank_lz(blank_c), .dp_mask(dp_c), .blink_en(blink_c), .busy(busy_c), .ovf(ovf_c),
        .ssegs(seg_c), .disp_en(en_c));

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic compare(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        tag   = tag_q.pop_front();
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic load_a_t(input int v, input logic s);
        bin_a  = 14'(v);
        sign_a = s;
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        $display("load A bin=%0d sign=%0d", v, s);
    endtask

    task automatic idle_a(output int cyc);
        cyc = 0;
        while (busy_a === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic convert_a(input int v, input logic s);
        int cyc;
        load_a_t(v, s);
        expect_val("busy_len_a", 14);
        idle_a(cyc);
        compare(cyc);
    endtask

    task automatic wait_en_a(input logic [3:0] want);
        int n;
        n = 0;
        while (en_a !== want && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_change_a(input logic [3:0] prev, output logic [31:0] obs);
        int n;
        n = 0;
        @(negedge clk);
        while (en_a === prev && n < 32) begin
            n++;
            @(negedge clk);
        end
        obs = (en_a !== prev) ? {28'b0, en_a} : 'x;
    endtask

    task automatic check_digit_a(input string tag, input int i, input logic [7:0] e);
        logic [3:0]  want;
        logic [31:0] obs;
        int          n;
        want = ~(4'b0001 << i);
        expect_val(tag, {24'b0, e});
        @(negedge clk);
        n = 0;
        while (en_a !== want && n < 64) begin
            n++;
            @(negedge clk);
        end
        obs = (en_a === want) ? {24'b0, seg_a} : 'x;
        compare(obs);
    endtask

    task automatic wait_change_b(input logic [2:0] prev, output logic [31:0] obs);
        int n;
        n = 0;
        @(negedge clk);
        while (en_b === prev && n < 32) begin
            n++;
            @(negedge clk);
        end
        obs = (en_b !== prev) ? {29'b0, en_b} : 'x;
    endtask

    task automatic check_digit_b(input string tag, input int i, input logic [7:0] e);
        logic [2:0]  want;
        logic [31:0] obs;
        int          n;
        want = ~(3'b001 << i);
        expect_val(tag, {24'b0, e});
        @(negedge clk);
        n = 0;
        while (en_b !== want && n < 64) begin
            n++;
            @(negedge clk);
        end
        obs = (en_b === want) ? {24'b0, seg_b} : 'x;
        compare(obs);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] obs;
        logic [3:0]  prev_a;
        logic [2:0]  prev_b;
        logic [7:0]  s[24];
        logic [3:0]  seq_a[4];
        logic [2:0]  seq_b[3];
        int          cyc;
        int          t;

        rst = 1'b1;
        {bin_a, bin_b, bin_c} = '0;
        {sign_a, sign_b, sign_c, load_a, load_b, load_c} = '0;
        {valid_a, valid_b, valid_c} = 3'b111;
        {blank_a, blank_b, blank_c} = 3'b000;
        {dp_a, dp_c, blink_a, blink_c} = '0;
        dp_b = '0;
        blink_b = '0;
        repeat (3) @(negedge clk);

        expect_val("rst_busy", 0);      compare(busy_a);
        expect_val("rst_ovf", 0);       compare(ovf_a);
        expect_val("rst_ssegs", 8'hFF); compare(seg_a);
        expect_val("rst_en_a", 4'hF);   compare(en_a);
        expect_val("rst_en_b", 3'h7);   compare(en_b);
        rst = 1'b0;
        @(negedge clk);
        expect_val("first_en_a", 4'b1110); compare(en_a);

        // 1234 and a full scan cycle
        load_a_t(1234, 1'b0);
        expect_val("busy_e0", 1); compare(busy_a);
        expect_val("busy_len_1234", 14);
        idle_a(cyc);
        compare(cyc);
        expect_val("ovf_1234", 0); compare(ovf_a);
        wait_en_a(4'b1110);
        seq_a = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        prev_a = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            expect_val("scan_a", {28'b0, seq_a[k]});
            wait_change_a(prev_a, obs);
            compare(obs);
            prev_a = obs[3:0];
        end
        check_digit_a("d0_1234", 0, 8'h99);
        check_digit_a("d1_1234", 1, 8'h0D);
        check_digit_a("d2_1234", 2, 8'h25);
        check_digit_a("d3_1234", 3, 8'h9F);

        // leading-zero blanking
        convert_a(7, 1'b0);
        blank_a = 1'b1;
        check_digit_a("lz_d3", 3, 8'hFF);
        check_digit_a("lz_d2", 2, 8'hFF);
        check_digit_a("lz_d1", 1, 8'hFF);
        check_digit_a("lz_d0", 0, 8'h1F);
        blank_a = 1'b0;
        check_digit_a("nolz_d3", 3, 8'h03);
        check_digit_a("nolz_d1", 1, 8'h03);
        check_digit_a("nolz_d0", 0, 8'h1F);
        convert_a(0, 1'b0);
        blank_a = 1'b1;
        check_digit_a("zero_d0", 0, 8'h03);
        check_digit_a("zero_d1", 1, 8'hFF);
        blank_a = 1'b0;

        // sign and overflow boundaries
        convert_a(999, 1'b1);
        expect_val("ovf_neg999", 0); compare(ovf_a);
        check_digit_a("neg_d3", 3, 8'hFD);
        check_digit_a("neg_d2", 2, 8'h09);
        check_digit_a("neg_d0", 0, 8'h09);
        convert_a(1000, 1'b1);
        expect_val("ovf_neg1000", 1); compare(ovf_a);
        check_digit_a("ovfn_d3", 3, 8'hFD);
        check_digit_a("ovfn_d1", 1, 8'hFD);
        check_digit_a("ovfn_d0", 0, 8'hFD);
        dp_a = 4'b0001;
        check_digit_a("ovf_dp_d0", 0, 8'hFC);
        dp_a = 4'b0000;
        convert_a(9999, 1'b0);
        expect_val("ovf_9999", 0); compare(ovf_a);
        check_digit_a("d3_9999", 3, 8'h09);
        convert_a(10000, 1'b0);
        expect_val("ovf_10000", 1); compare(ovf_a);

        // ovf holds through the next conversion
        load_a_t(9, 1'b0);
        expect_val("ovf_hold", 1); compare(ovf_a);
        idle_a(cyc);
        expect_val("ovf_clear", 0); compare(ovf_a);

        // load while busy is dropped; old value shown until commit
        wait_en_a(4'b0111);
        wait_change_a(4'b0111, obs);
        load_a_t(42, 1'b0);
        expect_val("hold_old", 8'h09); compare(seg_a);
        expect_val("busy_42", 1);      compare(busy_a);
        @(negedge clk);
        bin_a  = 14'd17;
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        expect_val("busy_rest_42", 12);
        idle_a(cyc);
        compare(cyc);
        repeat (3) @(negedge clk);
        expect_val("not_queued", 0); compare(busy_a);
        check_digit_a("d0_42", 0, 8'h25);
        check_digit_a("d1_42", 1, 8'h99);
        check_digit_a("d2_42", 2, 8'h03);

        // load held across the falling edge of busy
        bin_a  = 14'd5;
        sign_a = 1'b0;
        load_a = 1'b1;
        @(negedge clk);
        bin_a = 14'd6;
        expect_val("busy_len_5", 14);
        idle_a(cyc);
        compare(cyc);
        expect_val("fall_ignored", 0); compare(busy_a);
        @(negedge clk);
        expect_val("next_accept", 1);  compare(busy_a);
        load_a = 1'b0;
        idle_a(cyc);
        check_digit_a("d0_6", 0, 8'h41);

        // reset in the middle of a conversion
        load_a_t(123, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_val("abort_busy", 0);     compare(busy_a);
        expect_val("abort_ssegs", 8'hFF); compare(seg_a);
        expect_val("abort_en", 4'hF);    compare(en_a);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        expect_val("abort_no_commit", 0); compare(busy_a);
        check_digit_a("abort_d0", 0, 8'h03);
        check_digit_a("abort_d1", 1, 8'h03);

        // 3-digit scan, dp mask, valid override
        wait_change_b(3'b011, obs);
        while (en_b !== 3'b110 && t < 16) begin
            t++;
            @(negedge clk);
        end
        seq_b = '{3'b101, 3'b011, 3'b110};
        prev_b = 3'b110;
        for (int k = 0; k < 3; k++) begin
            expect_val("scan_b", {29'b0, seq_b[k]});
            wait_change_b(prev_b, obs);
            compare(obs);
            prev_b = obs[2:0];
        end
        dp_b = 3'b101;
        check_digit_b("dp_d0", 0, 8'h02);
        check_digit_b("dp_d1", 1, 8'h03);
        check_digit_b("dp_d2", 2, 8'h02);
        valid_b = 1'b0;
        check_digit_b("inv_d0", 0, 8'hFD);
        check_digit_b("inv_d1", 1, 8'hFD);
        check_digit_b("inv_d2", 2, 8'hFD);
        valid_b = 1'b1;

        // blink on a display that stays on digit 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bin_c  = 14'd5;
        load_c = 1'b1;
        @(negedge clk);
        load_c = 1'b0;
        $display("load C bin=5 sign=0");
        cyc = 0;
        while (busy_c === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        expect_val("busy_len_c", 14); compare(cyc);
        blink_c = 4'b1110;
        @(negedge clk);
        expect_val("en_c", 4'b1110); compare(en_c);
        for (int k = 0; k < 16; k++) begin
            expect_val("no_blink_d0", 8'h49);
            compare(seg_c);
            @(negedge clk);
        end
        blink_c = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            s[k] = seg_c;
            @(negedge clk);
        end
        t = 1;
        for (int k = 8; k >= 1; k--) begin
            if (s[k] !== s[k-1]) t = k;
        end
        expect_val("blink_pair", 8'h49 ^ 8'hFF);
        compare(s[t] ^ s[t-1]);
        for (int k = 0; k < 16; k++) begin
            expect_val("blink_run", ((k / 4) % 2 == 0) ? s[t] : s[t-1]);
            compare(s[t+k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
